// File: rtl/msx_slot_io_bridge_if.sv
// VDP CPU-port request bus: one valid/ready request with a separate
// read-data return strobe.
interface msx_slot_io_bridge_if;
  logic [1:0] bus_address;
  logic       bus_write;
  logic       bus_valid;
  logic       bus_ready;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_rdata_en;

  modport master (
    output bus_address,
    output bus_write,
    output bus_valid,
    output bus_wdata,
    input  bus_ready,
    input  bus_rdata,
    input  bus_rdata_en
  );

  modport slave (
    input  bus_address,
    input  bus_write,
    input  bus_valid,
    input  bus_wdata,
    output bus_ready,
    output bus_rdata,
    output bus_rdata_en
  );
endinterface

// File: rtl/msx_slot_io_bridge.sv
// MSX slot I/O front end: syncs Z80 strobes, decodes the VDP port window and
// issues one VDP bus request per I/O cycle. SLOT_WAIT_EN enables /WAIT stretch.
module msx_slot_io_bridge #(
  parameter logic [7:0] IO_BASE     = 8'h88,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slot_iorq_n,
  input  logic       slot_rd_n,
  input  logic       slot_wr_n,
  input  logic [7:0] slot_a,
  input  logic [7:0] slot_d_in,
  output logic [7:0] slot_d_out,
  output logic       slot_data_dir,
  output logic       slot_wait,
  msx_slot_io_bridge_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RDATA,
    S_HOLD
  } state_t;

  state_t r_state;

  logic [SYNC_STAGES-1:0] r_iorq_sync;
  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic [SYNC_STAGES-1:0] r_wr_sync;

  logic [1:0] r_addr;
  logic       r_write;
  logic       r_valid;
  logic [7:0] r_wdata;
  logic [7:0] r_dout;
  logic       r_dir;

  logic w_s_iorq;
  logic w_s_rd;
  logic w_s_wr;
  logic w_hit;
  logic w_match;

  // Flops preset to 1 so the strobes read as inactive out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iorq_sync <= '1;
      r_rd_sync   <= '1;
      r_wr_sync   <= '1;
    end else begin
      r_iorq_sync <= {r_iorq_sync[SYNC_STAGES-2:0], slot_iorq_n};
      r_rd_sync   <= {r_rd_sync[SYNC_STAGES-2:0], slot_rd_n};
      r_wr_sync   <= {r_wr_sync[SYNC_STAGES-2:0], slot_wr_n};
    end
  end

  assign w_s_iorq = ~r_iorq_sync[SYNC_STAGES-1];
  assign w_s_rd   = ~r_rd_sync[SYNC_STAGES-1];
  assign w_s_wr   = ~r_wr_sync[SYNC_STAGES-1];

  assign w_hit   = (slot_a[7:2] == IO_BASE[7:2]);
  assign w_match = w_s_iorq & (w_s_rd | w_s_wr) & w_hit;

`ifdef SLOT_WAIT_EN
  logic r_wait;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= 2'd0;
      r_write <= 1'b0;
      r_valid <= 1'b0;
      r_wdata <= 8'h00;
      r_dout  <= 8'h00;
      r_dir   <= 1'b0;
`ifdef SLOT_WAIT_EN
      r_wait  <= 1'b0;
`endif
    end else begin
      // Direction follows the synced strobes regardless of FSM progress.
      if (!w_s_iorq || !w_s_rd) begin
        r_dir <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_match) begin
            r_addr  <= slot_a[1:0];
            r_write <= w_s_wr;
            r_wdata <= slot_d_in;
            r_valid <= 1'b1;
            r_state <= S_REQ;
            if (!w_s_wr) begin
              r_dir <= 1'b1;
            end
`ifdef SLOT_WAIT_EN
            r_wait  <= 1'b1;
`endif
          end
        end
        S_REQ: begin
          if (bus.bus_ready) begin
            r_valid <= 1'b0;
            if (r_write) begin
              r_state <= S_HOLD;
`ifdef SLOT_WAIT_EN
              r_wait  <= 1'b0;
`endif
            end else if (bus.bus_rdata_en) begin
              r_dout  <= bus.bus_rdata;
              r_state <= S_HOLD;
`ifdef SLOT_WAIT_EN
              r_wait  <= 1'b0;
`endif
            end else begin
              r_state <= S_RDATA;
            end
          end
        end
        S_RDATA: begin
          if (bus.bus_rdata_en) begin
            r_dout  <= bus.bus_rdata;
            r_state <= S_HOLD;
`ifdef SLOT_WAIT_EN
            r_wait  <= 1'b0;
`endif
          end
        end
        S_HOLD: begin
          if (!w_s_iorq) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_address = r_addr;
  assign bus.bus_write   = r_write;
  assign bus.bus_valid   = r_valid;
  assign bus.bus_wdata   = r_wdata;

  assign slot_d_out    = r_dout;
  assign slot_data_dir = r_dir;

`ifdef SLOT_WAIT_EN
  assign slot_wait = r_wait;
`else
  assign slot_wait = 1'b0;
`endif

endmodule

// File: tb/tb_msx_slot_io_bridge.sv
// Directed bench for msx_slot_io_bridge: writes, reads, decode miss,
// long stall, same-cycle read data, reset in REQ and a write burst.
module tb_msx_slot_io_bridge;

  logic       clk;
  logic       reset;
  logic       slot_iorq_n;
  logic       slot_rd_n;
  logic       slot_wr_n;
  logic [7:0] slot_a;
  logic [7:0] slot_d_in;
  logic [7:0] slot_d_out;
  logic       slot_data_dir;
  logic       slot_wait;

  msx_slot_io_bridge_if bus();

  msx_slot_io_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .slot_iorq_n   (slot_iorq_n),
    .slot_rd_n     (slot_rd_n),
    .slot_wr_n     (slot_wr_n),
    .slot_a        (slot_a),
    .slot_d_in     (slot_d_in),
    .slot_d_out    (slot_d_out),
    .slot_data_dir (slot_data_dir),
    .slot_wait     (slot_wait),
    .bus           (bus)
  );

  int total = 0;
  int bad   = 0;

  int unsigned acc   = 0;
  int unsigned wsum  = 0;
  logic [7:0]  lastw = 8'h00;

`ifdef SLOT_WAIT_EN
  localparam logic WAIT_ON = 1'b1;
`else
  localparam logic WAIT_ON = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent count of accepted handshakes.
  always @(posedge clk) begin
    if (bus.bus_valid === 1'b1 && bus.bus_ready === 1'b1) begin
      acc   = acc + 1;
      wsum  = wsum + bus.bus_wdata;
      lastw = bus.bus_wdata;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic io_start(input logic [7:0] a,
                          input logic [7:0] d,
                          input logic is_wr);
    slot_a      = a;
    slot_d_in   = d;
    slot_iorq_n = 1'b0;
    slot_wr_n   = ~is_wr;
    slot_rd_n   = is_wr;
  endtask

  task automatic io_end();
    slot_iorq_n = 1'b1;
    slot_rd_n   = 1'b1;
    slot_wr_n   = 1'b1;
  endtask

  // Write with bus_ready tied high: one valid pulse, SYNC_STAGES+1 latency.
  task automatic wr_simple(input string tag,
                           input logic [7:0] a,
                           input logic [7:0] d);
    int unsigned a0;
    a0 = acc;
    bus.bus_ready = 1'b1;
    io_start(a, d, 1'b1);
    clks(2);
    chk({tag, "_v_early"}, 32'(bus.bus_valid), 32'd0);
    clks(1);
    chk({tag, "_fields"},
        {21'd0, bus.bus_valid, bus.bus_write, bus.bus_address, bus.bus_wdata},
        {21'd0, 1'b1, 1'b1, a[1:0], d});
    chk({tag, "_dir"}, 32'(slot_data_dir), 32'd0);
    clks(1);
    chk({tag, "_v_drop"}, 32'(bus.bus_valid), 32'd0);
    clks(2);
    io_end();
    clks(5);
    chk({tag, "_count"}, acc - a0, 32'd1);
    chk({tag, "_dir_end"}, 32'(slot_data_dir), 32'd0);
  endtask

  int unsigned a0;
  int unsigned s0;

  initial begin
    reset            = 1'b1;
    slot_iorq_n      = 1'b1;
    slot_rd_n        = 1'b1;
    slot_wr_n        = 1'b1;
    slot_a           = 8'h00;
    slot_d_in        = 8'h00;
    bus.bus_ready    = 1'b0;
    bus.bus_rdata    = 8'h00;
    bus.bus_rdata_en = 1'b0;
    clks(3);
    chk("rst_outs",
        {14'd0, slot_d_out, slot_data_dir, slot_wait, bus.bus_valid,
         bus.bus_write, bus.bus_address, bus.bus_wdata},
        32'd0);
    reset = 1'b0;
    clks(2);

    wr_simple("wr89", 8'h89, 8'h0A);

    // Read 0x89, data returned 2 clocks after acceptance.
    a0 = acc;
    bus.bus_ready = 1'b1;
    io_start(8'h89, 8'h00, 1'b0);
    clks(3);
    chk("rd_fields",
        {28'd0, bus.bus_valid, bus.bus_write, bus.bus_address},
        {28'd0, 1'b1, 1'b0, 2'd1});
    chk("rd_dir_set", 32'(slot_data_dir), 32'd1);
    chk("rd_wait", 32'(slot_wait), 32'(WAIT_ON));
    clks(2);
    bus.bus_rdata    = 8'h9F;
    bus.bus_rdata_en = 1'b1;
    clks(1);
    bus.bus_rdata_en = 1'b0;
    chk("rd_dout", 32'(slot_d_out), 32'h9F);
    chk("rd_dir_hold", 32'(slot_data_dir), 32'd1);
    chk("rd_v_drop", 32'(bus.bus_valid), 32'd0);
    chk("rd_wait_off", 32'(slot_wait), 32'd0);
    clks(1);
    io_end();
    clks(2);
    chk("rd_dir_late", 32'(slot_data_dir), 32'd1);
    clks(1);
    chk("rd_dir_clr", 32'(slot_data_dir), 32'd0);
    clks(3);
    chk("rd_count", acc - a0, 32'd1);

    // Outside the window.
    a0 = acc;
    io_start(8'h98, 8'h55, 1'b1);
    clks(8);
    chk("miss_dir", 32'(slot_data_dir), 32'd0);
    chk("miss_valid", 32'(bus.bus_valid), 32'd0);
    io_end();
    clks(4);
    chk("miss_count", acc - a0, 32'd0);

    // 40-clock stall on a write to 0x8B.
    a0 = acc;
    bus.bus_ready = 1'b0;
    io_start(8'h8B, 8'hC0, 1'b1);
    clks(3);
    for (int i = 0; i < 40; i++) begin
      chk("stall_fields",
          {21'd0, bus.bus_valid, bus.bus_write, bus.bus_address,
           bus.bus_wdata},
          {21'd0, 1'b1, 1'b1, 2'd3, 8'hC0});
      chk("stall_wait", 32'(slot_wait), 32'(WAIT_ON));
      clks(1);
    end
    bus.bus_ready = 1'b1;
    clks(1);
    chk("stall_v_drop", 32'(bus.bus_valid), 32'd0);
    chk("stall_wait_off", 32'(slot_wait), 32'd0);
    io_end();
    clks(5);
    chk("stall_count", acc - a0, 32'd1);
    chk("stall_lastw", 32'(lastw), 32'hC0);

    // Read data in the same cycle as ready skips RDATA.
    a0 = acc;
    bus.bus_ready = 1'b0;
    io_start(8'h8A, 8'h00, 1'b0);
    clks(3);
    chk("same_valid", 32'(bus.bus_valid), 32'd1);
    clks(1);
    bus.bus_ready    = 1'b1;
    bus.bus_rdata    = 8'h5A;
    bus.bus_rdata_en = 1'b1;
    clks(1);
    bus.bus_rdata_en = 1'b0;
    chk("same_dout", 32'(slot_d_out), 32'h5A);
    chk("same_v_drop", 32'(bus.bus_valid), 32'd0);
    chk("same_dir", 32'(slot_data_dir), 32'd1);
    chk("same_wait", 32'(slot_wait), 32'd0);
    io_end();
    clks(5);
    chk("same_dir_clr", 32'(slot_data_dir), 32'd0);
    chk("same_count", acc - a0, 32'd1);

    // Reset while a read is pending in REQ.
    bus.bus_ready = 1'b0;
    io_start(8'h8A, 8'h00, 1'b0);
    clks(3);
    chk("rreq_valid", 32'(bus.bus_valid), 32'd1);
    chk("rreq_dir", 32'(slot_data_dir), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rreq_outs",
        {14'd0, slot_d_out, slot_data_dir, slot_wait, bus.bus_valid,
         bus.bus_write, bus.bus_address, bus.bus_wdata},
        32'd0);
    io_end();
    clks(2);
    reset = 1'b0;
    clks(2);
    wr_simple("wr88", 8'h88, 8'h0A);

    // Back-to-back writes to 0x88.
    a0 = acc;
    s0 = wsum;
    for (int i = 0; i < 32; i++) begin
      io_start(8'h88, 8'(i), 1'b1);
      clks(6);
      io_end();
      clks(4);
    end
    chk("b2b_count", acc - a0, 32'd32);
    chk("b2b_sum", wsum - s0, 32'd496);
    chk("b2b_lastw", 32'(lastw), 32'd31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msx_slot_io_bridge.md
Name: msx_slot_io_bridge

Overview:
- Front-end stage between the MSX cartridge slot pins and the VDP core's CPU-port bus.
- Synchronises the asynchronous Z80 /IORQ, /RD and /WR strobes into the clk domain and decodes the 4-port VDP I/O window (default 0x88-0x8B).
- Issues exactly one valid/ready bus transaction per Z80 I/O cycle.
- For reads, returns the VDP data to the slot data bus and controls the data-bus direction.

Parameters:
- IO_BASE, 8'h88, base I/O address; slot_a[7:2] must equal IO_BASE[7:2].
- SYNC_STAGES, 2, flip-flop synchroniser depth for slot_iorq_n, slot_rd_n and slot_wr_n (minimum 2).

Ports:
- clk  in  1  system clock (85.9 MHz).
- reset  in  1  asynchronous, active-high reset.
- slot_iorq_n  in  1  Z80 /IORQ (asynchronous).
- slot_rd_n  in  1  Z80 /RD (asynchronous).
- slot_wr_n  in  1  Z80 /WR (asynchronous).
- slot_a  in  8  Z80 A[7:0].
- slot_d_in  in  8  slot data bus, input path.
- slot_d_out  out  8  read data driven to the slot.
- slot_data_dir  out  1  1 = cartridge drives slot_d; 0 = Hi-Z / CPU drives.
- slot_wait  out  1  Z80 /WAIT request, active-high.
- bus_address  out  2  VDP port number (slot_a[1:0]).
- bus_write  out  1  1 = write, 0 = read.
- bus_valid  out  1  request valid.
- bus_ready  in  1  VDP accepts the request this cycle.
- bus_wdata  out  8  write data.
- bus_rdata  in  8  read data.
- bus_rdata_en  in  1  bus_rdata is valid this cycle.

Behaviour:
- Reset: async, active-high. All outputs are 0: slot_d_out = 8'h00, slot_data_dir = 0, slot_wait = 0, bus_valid = 0, bus_write = 0, bus_address = 0, bus_wdata = 0. Synchroniser flops preset to 1. FSM = IDLE.
- Synchroniser: the strobes pass through SYNC_STAGES flops. s_iorq, s_rd and s_wr denote the synchronised, active-high versions.
- slot_a and slot_d_in are sampled without synchronisation when a cycle is accepted. They are stable by then because the synchronised strobe is later than the pin edge.
- Match condition: s_iorq & (s_rd | s_wr) & (slot_a[7:2] == IO_BASE[7:2]). Level-qualified.
- IDLE:
  - On match, latch bus_address = slot_a[1:0], bus_write = s_wr, bus_wdata = slot_d_in.
  - Assert bus_valid next cycle; go to REQ.
  - If s_rd and s_wr are both true, s_wr wins (write).
  - Pin edge to bus_valid latency is SYNC_STAGES + 1 clocks.
- REQ:
  - Hold bus_valid and all bus_* fields constant until bus_ready = 1.
  - On the ready cycle, bus_valid drops next cycle.
  - After a write, go to HOLD. After a read, go to RDATA.
- RDATA:
  - Wait for bus_rdata_en. Latch slot_d_out = bus_rdata and go to HOLD.
  - If bus_rdata_en arrives in the same cycle as bus_ready, latch it directly and skip RDATA.
- HOLD: wait until s_iorq = 0, then return to IDLE. This guarantees one transaction per Z80 cycle.
- slot_data_dir:
  - Set to 1 when a read cycle is accepted in IDLE.
  - Cleared combinationally-registered (1 clk) once s_iorq = 0 or s_rd = 0.
  - Never set during writes or for non-matching addresses.
- Early release: if /IORQ is released before the transaction completes:
  - The bus transaction still completes; bus_valid is never withdrawn.
  - slot_data_dir drops immediately.
  - Late read data is consumed, slot_d_out is updated, and the FSM then returns to IDLE.
- Non-matching address: no bus activity and no direction change.
- Reset mid-operation: FSM returns to IDLE. Any in-flight request is abandoned and bus_valid goes to 0 immediately.

Optional Feature:
- Macro: SLOT_WAIT_EN.
- Defined: slot_wait = 1 from acceptance in IDLE until the write is acknowledged (bus_ready) or the read data is latched. It is then 0 from the next clock, which stretches the Z80 cycle while the VDP is busy.
- Not defined: slot_wait is tied to 0. The bus relies on the VDP responding within one Z80 TW state.

Test Plan:
- Write 8'h0A to port 0x89, bus_ready tied to 1 -> single bus_valid pulse with bus_address = 1, bus_write = 1, bus_wdata = 8'h0A; slot_data_dir stays 0.
- Read port 0x89, VDP returns 8'h9F with bus_rdata_en 2 clks after bus_ready -> slot_data_dir = 1, slot_d_out = 8'h9F before /IORQ rises; slot_data_dir = 0 within SYNC_STAGES + 1 clks after /IORQ rises.
- Write port 0x98 (outside the window) -> no bus_valid, slot_data_dir = 0.
- Hold bus_ready = 0 for 40 clks during a write to 0x8B with 8'hC0 -> bus_valid and fields stay stable; exactly one acceptance. With SLOT_WAIT_EN, slot_wait = 1 for the whole stall.
- Assert reset while in REQ -> bus_valid, slot_data_dir and slot_wait all 0 at once. The next write to 0x88 then behaves as in scenario 1.
- 32 back-to-back writes to 0x88 -> exactly 32 bus transactions, no duplicates.
